hamming_secded_decoder: RTL and testbench
=========================================

Name: hamming_secded_decoder

Overview:
- Downstream stage of the Hamming encoder. Accepts 13-bit SEC-DED codewords: 8 data bits, 4 Hamming parity bits and 1 overall parity bit.
- Computes the syndrome, corrects any single-bit error, flags uncorrectable errors, and returns the 8-bit data.
- Two-stage pipeline with a valid/ready handshake on both sides.
- Keeps saturating error statistics counters.

Parameters:
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  code_in is valid.
- in_ready  out  1  decoder can accept code_in this cycle.
- code_in  in  13  codeword. Bit k (k = 1..12) is Hamming position k. Bit 0 is overall even parity over bits 12:0.
- out_valid  out  1  data_out and flags are valid.
- out_ready  in  1  consumer accepts the output.
- data_out  out  8  decoded, corrected data.
- err_corr  out  1  a single-bit error was corrected, including an error in the overall parity bit.
- err_uncorr  out  1  uncorrectable (double or invalid) error.
- syndrome  out  4  registered syndrome, for debug.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of corrected words, saturating.
- uncorr_cnt  out  CNT_W  count of uncorrectable words, saturating.

Behaviour:
- Reset: every output and internal register goes to 0, including out_valid, both counters, data_out, the flags and syndrome.
- Clocking and reset: single clock domain. Reset is asynchronous and active-high; reset mid-operation discards any in-flight words.
- Pipeline advance enable: en = !out_valid || out_ready. in_ready = en, combinationally.
- An input transfer occurs on in_valid && in_ready. The stage-1 valid bit is loaded with in_valid when en is high and holds otherwise.
- Bubbles are not collapsed.
- Latency: exactly 2 cycles from input transfer to out_valid when not stalled. Full throughput is 1 word per cycle.
- While out_valid && !out_ready, all pipeline registers and outputs hold stable.
- Data positions: data[0..7] map to code positions 3, 5, 6, 7, 9, 10, 11, 12.
- Syndrome: syndrome bit i is the XOR of all positions 1..12 whose index has bit i set.
- Overall parity: p = XOR of code_in[12:0].
- Stage 1 registers the raw codeword, the syndrome s and p.
- Stage 2 classifies, corrects and registers the outputs:
  - s=0, p=0: no error. Both flags 0; data is extracted unchanged.
  - s=0, p=1: error in bit 0 only. err_corr=1; data unchanged.
  - s in 1..12, p=1: flip position s, then extract. err_corr=1.
  - s in 13..15, p=1: err_uncorr=1; data is extracted raw.
  - s!=0, p=0: double error. err_uncorr=1; data is extracted raw.
- err_corr and err_uncorr are never both 1.
- Counters:
  - Increment on the output transfer (out_valid && out_ready) according to the flags.
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority over a same-cycle increment: the result is 0.

Decomposition:
- Shared package hamming_pkg holds:
  - DATA_W=8, PAR_W=4, CODE_W=13;
  - the data-position constant array;
  - a function computing the syndrome from a codeword;
  - a function extracting data from a codeword.
- The encoder will reuse the package.
- One sub-module: hamming_err_counter, a saturating counter with clear and increment, instantiated twice.

Test Plan:
- Clean word: code_in=13'h14D8 (encoding of data 0xAD) -> after 2 cycles data_out=8'hAD, syndrome=0, both flags 0, counters unchanged.
- Single error at position 6: code_in=13'h1498 -> data_out=8'hAD, syndrome=6, err_corr=1, corr_cnt increments by 1.
- Overall-parity-bit error: code_in=13'h14D9 -> data_out=8'hAD, syndrome=0, err_corr=1.
- Double error at positions 3 and 5: code_in=13'h14F0 -> syndrome=6, err_uncorr=1, err_corr=0, uncorr_cnt increments by 1.
- Backpressure: stream 4 words back-to-back and hold out_ready=0 for 3 cycles -> in_ready=0 while stalled; outputs hold stable; all 4 words emerge in order with none lost or duplicated.
- Counter edge cases:
  - with CNT_W=2, drive 5 corrected words -> corr_cnt saturates at 3;
  - assert cnt_clr in the same cycle as a transfer -> counter reads 0;
  - assert rst mid-stream -> out_valid=0 immediately, asynchronously.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared SEC-DED (13,8) code constants and helpers
package hamming_pkg;

   localparam int DATA_W = 8;
   localparam int PAR_W  = 4;
   localparam int CODE_W = 13;

   // Code position of data bit i; entry 0 is the rightmost element.
   localparam logic [DATA_W-1:0][PAR_W-1:0] DATA_POS = {
      4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
   };

   function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W-1:0] code);
      logic [PAR_W-1:0] s;
      s = '0;
      for (int k = 1; k < CODE_W; k++) begin
         for (int i = 0; i < PAR_W; i++) begin
            if (k[i]) begin
               s[i] = s[i] ^ code[k];
            end
         end
      end
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < DATA_W; i++) begin
         d[i] = code[DATA_POS[i]];
      end
      return d;
   endfunction

endpackage

// File: rtl/hamming_err_counter.sv
// rtl/hamming_err_counter.sv - saturating event counter with synchronous clear
module hamming_err_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hamming_secded_decoder.sv
// rtl/hamming_secded_decoder.sv - two-stage SEC-DED decoder with error statistics
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CODE_W-1:0]   code_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   data_out,
   output logic                err_corr,
   output logic                err_uncorr,
   output logic [PAR_W-1:0]    syndrome,
   input  logic                cnt_clr,
   output logic [CNT_W-1:0]    corr_cnt,
   output logic [CNT_W-1:0]    uncorr_cnt
);

   logic                en;
   logic                s1_valid;
   logic [CODE_W-1:0]   s1_code;
   logic [PAR_W-1:0]    s1_syn;
   logic                s1_par;

   logic                syn_in_range;
   logic                corr_d;
   logic                uncorr_d;
   logic [CODE_W-1:0]   fixed_code;
   logic [DATA_W-1:0]   data_d;
   logic                out_xfer;

   // Whole pipeline freezes while the output is stalled.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_code <= code_in;
            s1_syn  <= calc_syndrome(code_in);
            s1_par  <= ^code_in;
         end
      end
   end

   always_comb begin
      syn_in_range = (s1_syn != '0) && (s1_syn <= PAR_W'(CODE_W - 1));
      corr_d       = s1_par && ((s1_syn == '0) || syn_in_range);
      uncorr_d     = (s1_par && !syn_in_range && (s1_syn != '0)) ||
                     (!s1_par && (s1_syn != '0));
      fixed_code   = s1_code;
      if (s1_par && syn_in_range) begin
         fixed_code = s1_code ^ (CODE_W'(1) << s1_syn);
      end
      data_d = extract_data(fixed_code);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         data_out   <= '0;
         err_corr   <= 1'b0;
         err_uncorr <= 1'b0;
         syndrome   <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            data_out   <= data_d;
            err_corr   <= corr_d;
            err_uncorr <= uncorr_d;
            syndrome   <= s1_syn;
         end
      end
   end

   hamming_err_counter #(.W(CNT_W)) u_corr_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (out_xfer && err_corr),
      .count (corr_cnt)
   );

   hamming_err_counter #(.W(CNT_W)) u_uncorr_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (out_xfer && err_uncorr),
      .count (uncorr_cnt)
   );

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb/tb_hamming_secded_decoder.sv - directed self-checking bench for the SEC-DED decoder
module tb_hamming_secded_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [12:0] code_in;
   logic [7:0]  data_out;
   logic        err_corr, err_uncorr, cnt_clr;
   logic [3:0]  syndrome;
   logic [15:0] corr_cnt, uncorr_cnt;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [12:0] s_code_in;
   logic [7:0]  s_data_out;
   logic        s_err_corr, s_err_uncorr, s_cnt_clr;
   logic [3:0]  s_syndrome;
   logic [1:0]  s_corr_cnt, s_uncorr_cnt;

   int tests_run = 0;
   int tests_failed = 0;
   int m_corr = 0;
   int m_unc = 0;

   always #5 clk = ~clk;

   hamming_secded_decoder #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .err_corr(err_corr),
      .err_uncorr(err_uncorr), .syndrome(syndrome), .cnt_clr(cnt_clr),
      .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   hamming_secded_decoder #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .code_in(s_code_in),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .data_out(s_data_out), .err_corr(s_err_corr),
      .err_uncorr(s_err_uncorr), .syndrome(s_syndrome), .cnt_clr(s_cnt_clr),
      .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tests_run++;
      if ({out_valid, data_out, err_corr, err_uncorr, syndrome} !== 15'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h want 0", {out_valid, data_out, err_corr, err_uncorr, syndrome});
      end
      tests_run++;
      if ({corr_cnt, uncorr_cnt} !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_counters: got %h/%h want 0/0", corr_cnt, uncorr_cnt);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic send_word(input logic [12:0] code, input logic [7:0] e_data, input logic [3:0] e_syn,
                            input logic e_corr, input logic e_unc, input string name);
      in_valid = 1'b1;
      code_in  = code;
      step();
      in_valid = 1'b0;
      step();
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_latency: out_valid got %b want 1", name, out_valid);
      end
      tests_run++;
      if ({data_out, syndrome, err_corr, err_uncorr} !== {e_data, e_syn, e_corr, e_unc}) begin
         tests_failed++;
         $display("FAIL %s_result: data/syn/corr/unc got %h/%0d/%b/%b want %h/%0d/%b/%b",
                  name, data_out, syndrome, err_corr, err_uncorr, e_data, e_syn, e_corr, e_unc);
      end
      if (e_corr) m_corr++;
      if (e_unc) m_unc++;
      step();
      tests_run++;
      if (out_valid !== 1'b0 || corr_cnt !== 16'(m_corr) || uncorr_cnt !== 16'(m_unc)) begin
         tests_failed++;
         $display("FAIL %s_counters: valid/corr/unc got %b/%0d/%0d want 0/%0d/%0d",
                  name, out_valid, corr_cnt, uncorr_cnt, m_corr, m_unc);
      end
   endtask

   task automatic test_decode();
      send_word(13'h14D8, 8'hAD, 4'd0,  1'b0, 1'b0, "clean");
      send_word(13'h1498, 8'hAD, 4'd6,  1'b1, 1'b0, "single_pos6");
      send_word(13'h14D9, 8'hAD, 4'd0,  1'b1, 1'b0, "overall_bit");
      send_word(13'h14F0, 8'hAE, 4'd6,  1'b0, 1'b1, "double_3_5");
      send_word(13'h04D8, 8'hAD, 4'd12, 1'b1, 1'b0, "single_pos12");
      send_word(13'h14DA, 8'hAD, 4'd1,  1'b1, 1'b0, "single_pos1");
      send_word(13'h15CA, 8'hAD, 4'd13, 1'b0, 1'b1, "invalid_syn13");
   endtask

   task automatic test_back_to_back();
      logic [12:0] bp_code [4];
      logic [13:0] exp_tup [4];
      logic [13:0] got_tup [8];
      logic [14:0] snap;
      logic        stalled_prev;
      int          n_in, n_out;
      bp_code = '{13'h14D8, 13'h1498, 13'h14D9, 13'h14F0};
      exp_tup = '{{8'hAD, 4'd0, 2'b00}, {8'hAD, 4'd6, 2'b10}, {8'hAD, 4'd0, 2'b10}, {8'hAE, 4'd6, 2'b01}};
      n_in = 0;
      n_out = 0;
      stalled_prev = 1'b0;
      snap = '0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready = !(cyc >= 3 && cyc < 6);
         #1;
         in_valid = (n_in < 4);
         if (n_in < 4) code_in = bp_code[n_in];
         #1;
         if (stalled_prev) begin
            tests_run++;
            if ({out_valid, data_out, syndrome, err_corr, err_uncorr} !== snap) begin
               tests_failed++;
               $display("FAIL stall_hold cyc%0d: got %h want %h", cyc,
                        {out_valid, data_out, syndrome, err_corr, err_uncorr}, snap);
            end
         end
         if (out_valid && !out_ready) begin
            tests_run++;
            if (in_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL stall_in_ready cyc%0d: got %b want 0", cyc, in_ready);
            end
         end
         if (in_valid && in_ready) n_in++;
         if (out_valid && out_ready && n_out < 8) begin
            got_tup[n_out] = {data_out, syndrome, err_corr, err_uncorr};
            n_out++;
         end
         stalled_prev = out_valid && !out_ready;
         snap = {out_valid, data_out, syndrome, err_corr, err_uncorr};
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tests_run++;
      if (n_out != 4) begin
         tests_failed++;
         $display("FAIL bp_word_count: got %0d want 4", n_out);
      end
      for (int i = 0; i < 4; i++) begin
         if (i < n_out) begin
            tests_run++;
            if (got_tup[i] !== exp_tup[i]) begin
               tests_failed++;
               $display("FAIL bp_order word%0d: got %h want %h", i, got_tup[i], exp_tup[i]);
            end
         end
      end
      m_corr += 2;
      m_unc += 1;
      tests_run++;
      if (corr_cnt !== 16'(m_corr) || uncorr_cnt !== 16'(m_unc)) begin
         tests_failed++;
         $display("FAIL bp_counters: got %0d/%0d want %0d/%0d", corr_cnt, uncorr_cnt, m_corr, m_unc);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) begin
         s_in_valid = 1'b1;
         s_code_in  = 13'h1498;
         step();
      end
      s_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      tests_run++;
      if (s_corr_cnt !== 2'd3 || s_uncorr_cnt !== 2'd0) begin
         tests_failed++;
         $display("FAIL sat_counter: got %0d/%0d want 3/0", s_corr_cnt, s_uncorr_cnt);
      end
   endtask

   task automatic test_cnt_clr();
      in_valid = 1'b1;
      code_in  = 13'h1498;
      step();
      in_valid = 1'b0;
      step();
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      m_corr = 0;
      m_unc = 0;
      tests_run++;
      if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL clr_priority: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
      end
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1;
      code_in  = 13'h14D8;
      step();
      step();
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_precondition: out_valid got %b want 1", out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || data_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL rst_async: valid/data got %b/%h want 0/00", out_valid, data_out);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b0;
      step();
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_discard: out_valid got %b want 0", out_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      code_in = '0;
      cnt_clr = 1'b0;
      s_in_valid = 1'b0;
      s_out_ready = 1'b1;
      s_code_in = '0;
      s_cnt_clr = 1'b0;
      step();
      step();
      test_reset();
      rst = 1'b0;
      step();
      test_decode();
      test_back_to_back();
      test_saturation();
      test_cnt_clr();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
